snail_tx: RTL and testbench
===========================

# snail_tx

Serial stimulus transmitter for the snail pattern detector: accepts a W-bit word over a valid/ready handshake, shifts it out MSB-first on a single-bit line `D` (one bit per clock) and follows each word with GAP forced-zero cycles. A built-in shadow copy of the detector FSM produces `exp_q`, the cycle-exact expected detector output `Q`, and counts HOORAY entries per word. It sits on the drive side of the detector in the lab top level and doubles as a self-checking source.

## Interface
- `W`, default 8: word width in bits, W ≥ 2.
- `GAP`, default 2: zero-bit cycles after each word, GAP ≥ 1; returns the detector to SAD.
- `clk`  in  1  clock, all state updates on rising edge.
- `_rst`  in  1  reset, asynchronous, active-low.
- `data`  in  W  word to transmit; sampled only on accept.
- `valid`  in  1  `data` is offered.
- `ready`  out  1  high only in IDLE; accept = `valid & ready` at a rising edge.
- `D`  out  1  serial bit stream to the detector; registered.
- `busy`  out  1  high in SEND and GAP.
- `exp_q`  out  1  expected detector `Q`; registered.
- `hits`  out  $clog2(W+1)  number of cycles with `exp_q`=1 for the current or last word.
- `done`  out  1  one-cycle pulse on return to IDLE after a word.

## Operation
- Control FSM states: IDLE, SEND, GAP.
  - IDLE: `D`=0, `ready`=1. On accept, load the shift register with `data`, load the bit counter with W-1, clear `hits` and go to SEND.
  - SEND: `D` = current MSB; shift left each cycle. After W bits go to GAP with the gap counter set to GAP-1.
  - GAP: `D`=0. After GAP cycles go to IDLE and pulse `done`.
- Shadow FSM (SAD/HOPE/HOORAY, reset SAD) is clocked from the registered `D`:
  - SAD: D=1 → HOPE.
  - HOPE: D=1 → HOORAY.
  - HOORAY: D=1 → HOPE.
  - Any state: D=0 → SAD.
  - `exp_q` = (shadow == HOORAY).
- A run of k ones yields floor(k/2) `exp_q` pulses.
- `hits` increments on each edge where the shadow FSM enters HOORAY. It saturates at 2^width-1, which is unreachable for legal W. It holds from `done` until the next accept.
- `valid` and `data` are ignored outside IDLE. Dropping `valid` mid-word has no effect.
- Reset (any time, including mid-word) sets these values immediately:
  - state IDLE, shadow SAD;
  - `D`=0, `busy`=0, `exp_q`=0, `done`=0, `hits`=0, `ready`=1.
  - After release no `done` is produced for the aborted word.

## Timing
- Cycle k = the cycle following rising edge t0+k, where t0 is the accept edge.
- Bit `data[W-1-i]` drives `D` in cycle i, for i = 0..W-1. Latency from accept to first bit is 1 edge.
- `exp_q` in cycle i+1 reflects bit i, aligned with the detector `Q` when both share `clk`/`_rst`.
- Gap cycles are W..W+GAP-1. The last bit's `exp_q` appears in cycle W, so `hits` is final by cycle W+1 ≤ W+GAP.
- Cycle W+GAP: IDLE, `ready`=1, `done`=1, `busy`=0.
- Accept in the `done` cycle is legal. Back-to-back period is W+GAP+1 cycles, with `D`=0 in the IDLE cycle.

## Test plan
All scenarios use W=8, GAP=2.
- **Reset:** assert `_rst`=0 asynchronously between edges → `D`, `busy`, `exp_q`, `done`, `hits` = 0 and `ready`=1 without waiting for a clock edge.
- **Word 8'b1111_0000:**
  - `D` = 1,1,1,1,0,0,0,0,0,0 in cycles 0-9.
  - `exp_q`=1 only in cycles 2 and 4.
  - `done` in cycle 10 with `hits`=2.
- **Word 8'b1011_0111:** `exp_q`=1 only in cycles 4 and 7; `hits`=2 at `done`.
- **Word 8'hFF:**
  - `exp_q`=1 in cycles 2, 4, 6, 8; cycle 8 is the first gap cycle.
  - `hits`=4; `done` in cycle 10.
  - `exp_q` matches the detector `Q` every cycle when the two are connected.
- **Back-to-back:** `valid` held high with 8'hA5 then 8'h3C:
  - second accept at the end of cycle 10; second word's bit 0 on `D` in cycle 11;
  - `ready`=0 in cycles 0-9;
  - `data` changes during SEND do not alter `D`.
- **Mid-word reset:** 8'hFF accepted, `_rst` pulled low in cycle 3:
  - outputs go to reset values at once;
  - after release, no `done` appears;
  - next word 8'b1100_0000 gives `hits`=1 and `exp_q` in cycle 2 only.

Source files
------------

// File: rtl/snail_tx.sv
// snail_tx -- serial stimulus transmitter for the snail pattern detector.
//
// Accepts a W-bit word over a valid/ready handshake and shifts it out
// MSB-first on D, one bit per clock. Each word is followed by GAP
// forced-zero cycles, which return the detector to SAD. A shadow copy of
// the detector FSM, clocked from the registered D, produces exp_q: the
// cycle-exact expected detector output Q. The bench side can compare
// exp_q against Q directly.
//
// Handshake: a word is accepted on a rising edge where valid & ready.
// ready is high only in IDLE. valid and data are ignored at every other
// time, so dropping valid or changing data mid-word has no effect.
//
// Ports:
//   clk    in   clock; all state updates on the rising edge
//   _rst   in   asynchronous active-low reset
//   data   in   W-bit word; sampled only on accept
//   valid  in   data is offered
//   ready  out  high only in IDLE
//   D      out  registered serial bit stream to the detector
//   busy   out  high in SEND and GAP
//   exp_q  out  registered expected detector Q
//   hits   out  HOORAY entries for the current or last word
//   done   out  one-cycle pulse on the return to IDLE after a word
module snail_tx #(
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic                   clk,
    input  logic                   _rst,
    input  logic [W-1:0]           data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   D,
    output logic                   busy,
    output logic                   exp_q,
    output logic [$clog2(W+1)-1:0] hits,
    output logic                   done
);

    localparam int HW = $clog2(W + 1);
    localparam int CW = $clog2(W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SAD    = 2'd0,
        SH_HOPE   = 2'd1,
        SH_HOORAY = 2'd2
    } shadow_t;

    state_t          state;
    shadow_t         shadow;
    shadow_t         shadow_nxt;
    logic [W-1:0]    sh;
    logic [CW-1:0]   bitcnt;
    logic [GW-1:0]   gapcnt;
    logic            accept;

    assign ready  = (state == S_IDLE);
    assign accept = valid & ready;

    // Control FSM. sh holds the bits still to be sent: the MSB goes
    // straight into D on accept, so D is registered and the first bit
    // appears one edge after accept.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state  <= S_IDLE;
            sh     <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            D      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    D <= 1'b0;
                    if (valid) begin
                        D      <= data[W-1];
                        sh     <= {data[W-2:0], 1'b0};
                        bitcnt <= CW'(W - 1);
                        busy   <= 1'b1;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bitcnt != '0) begin
                        D      <= sh[W-1];
                        sh     <= {sh[W-2:0], 1'b0};
                        bitcnt <= bitcnt - 1'b1;
                    end else begin
                        D      <= 1'b0;
                        gapcnt <= GW'(GAP - 1);
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    D <= 1'b0;
                    if (gapcnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        gapcnt <= gapcnt - 1'b1;
                    end
                end
                default: begin
                    D     <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Shadow detector transition, driven from the registered D so that
    // exp_q lines up with the real detector's Q on the same clk/_rst.
    always_comb begin
        shadow_nxt = SH_SAD;
        if (D) begin
            case (shadow)
                SH_SAD:    shadow_nxt = SH_HOPE;
                SH_HOPE:   shadow_nxt = SH_HOORAY;
                SH_HOORAY: shadow_nxt = SH_HOPE;
                default:   shadow_nxt = SH_SAD;
            endcase
        end
    end

    // D is zero in the IDLE cycle of an accept, so an accept never
    // coincides with a HOORAY entry; clearing on accept loses nothing.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            shadow <= SH_SAD;
            exp_q  <= 1'b0;
            hits   <= '0;
        end else begin
            shadow <= shadow_nxt;
            exp_q  <= (shadow_nxt == SH_HOORAY);
            if (accept) begin
                hits <= '0;
            end else if (shadow_nxt == SH_HOORAY && shadow != SH_HOORAY
                         && hits != {HW{1'b1}}) begin
                hits <= hits + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snail_tx.sv
// Bench for snail_tx with W=8, GAP=2.
//
// Reference model: on each accept it precomputes the per-cycle expected
// D / exp_q / hits for the whole word from the rules "bit i of the word
// (MSB first) drives D in cycle i, then GAP zeros" and "exp_q in cycle
// c+1 is 1 when the run of ones ending at cycle c has even, non-zero
// length". A compare process checks every output on every negedge.
// Directed scenarios add hand-computed literal checks.
module tb_snail_tx;

  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int HW  = $clog2(W + 1);

  logic          clk;
  logic          _rst;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          D;
  logic          busy;
  logic          exp_q;
  logic [HW-1:0] hits;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  snail_tx #(.W(W), .GAP(GAP)) dut (
    .clk   (clk),
    ._rst  (_rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .D     (D),
    .busy  (busy),
    .exp_q (exp_q),
    .hits  (hits),
    .done  (done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          d;
    logic          e;
    logic [HW-1:0] h;
  } ent_t;

  ent_t          exp_fifo[$];
  logic          m_done;
  logic [HW-1:0] m_hits;
  logic          m_was_idle;
  int            m_run;
  int            m_cum;
  logic          m_d;
  logic          m_e;

  always @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      exp_fifo.delete();
      m_done = 1'b0;
      m_hits = '0;
    end else begin
      m_was_idle = (exp_fifo.size() == 0);
      m_done = 1'b0;
      if (!m_was_idle) begin
        void'(exp_fifo.pop_front());
        if (exp_fifo.size() == 0) m_done = 1'b1;
      end else if (valid) begin
        m_run = 0;
        m_cum = 0;
        for (int c = 0; c < W + GAP; c++) begin
          m_d = (c < W) ? data[W-1-c] : 1'b0;
          m_e = (c > 0) && (m_run > 0) && (m_run % 2 == 0);
          m_run = m_d ? m_run + 1 : 0;
          if (m_e) m_cum++;
          exp_fifo.push_back('{d: m_d, e: m_e, h: HW'(m_cum)});
        end
      end
      if (exp_fifo.size() != 0) m_hits = exp_fifo[0].h;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (_rst) begin
      if (exp_fifo.size() != 0) begin
        chk("d",     32'(D),     32'(exp_fifo[0].d));
        chk("exp_q", 32'(exp_q), 32'(exp_fifo[0].e));
        chk("busy",  32'(busy),  32'd1);
        chk("ready", 32'(ready), 32'd0);
      end else begin
        chk("d",     32'(D),     32'd0);
        chk("exp_q", 32'(exp_q), 32'd0);
        chk("busy",  32'(busy),  32'd0);
        chk("ready", 32'(ready), 32'd1);
      end
      chk("done", 32'(done), 32'(m_done));
      chk("hits", 32'(hits), 32'(m_hits));
    end
  end

  // ---------------- driver tasks ----------------
  // Sends one word from IDLE and logs D/exp_q/ready for cycles 0..10.
  task automatic run_word(input logic [7:0] w,
                          output logic [10:0] dl, output logic [10:0] el,
                          output logic [10:0] rl, output logic done10,
                          output logic [HW-1:0] hits10);
    @(posedge clk); #2;
    valid = 1'b1;
    data  = w;
    @(posedge clk); #2;
    valid = 1'b0;
    data  = 8'($urandom_range(0, 255));
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      dl[c] = D;
      el[c] = exp_q;
      rl[c] = ready;
      if (c == 10) begin
        done10 = done;
        hits10 = hits;
      end
      @(posedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_d"},     32'(D),     32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_exp_q"}, 32'(exp_q), 32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_hits"},  32'(hits),  32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [10:0]   dl, el, rl;
  logic          d10;
  logic [HW-1:0] h10;
  logic [18:0]   bl, br;
  logic [7:0]    w1, w2;
  logic          seen_done;

  initial begin
    _rst  = 1'b1;
    valid = 1'b0;
    data  = '0;

    // asynchronous reset between edges
    #2 _rst = 1'b0;
    #1 check_reset_vals("rst0");
    @(posedge clk);
    @(posedge clk); #2;
    _rst = 1'b1;

    // 1111_0000
    run_word(8'b1111_0000, dl, el, rl, d10, h10);
    chk("f0_d",    32'(dl), 32'b000_0000_1111);
    chk("f0_expq", 32'(el), 32'b000_0001_0100);
    chk("f0_done", 32'(d10), 32'd1);
    chk("f0_hits", 32'(h10), 32'd2);

    // 1011_0111
    run_word(8'b1011_0111, dl, el, rl, d10, h10);
    chk("b7_expq", 32'(el), 32'b000_1001_0000);
    chk("b7_done", 32'(d10), 32'd1);
    chk("b7_hits", 32'(h10), 32'd2);

    // FF
    run_word(8'hFF, dl, el, rl, d10, h10);
    chk("ff_d",     32'(dl), 32'b000_1111_1111);
    chk("ff_expq",  32'(el), 32'b001_0101_0100);
    chk("ff_ready", 32'(rl), 32'b100_0000_0000);
    chk("ff_done",  32'(d10), 32'd1);
    chk("ff_hits",  32'(h10), 32'd4);

    // back-to-back: valid held high, A5 then 3C; data changes mid-SEND
    w1 = 8'hA5;
    w2 = 8'h3C;
    @(posedge clk); #2;
    valid = 1'b1;
    data  = w1;
    @(posedge clk); #2;
    data = w2;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      bl[c] = D;
      br[c] = ready;
      @(posedge clk);
      if (c == 10) begin
        #2 valid = 1'b0;
      end
    end
    chk("b2b_ready", 32'(br[10:0]), 32'b100_0000_0000);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_w1_bit", 32'(bl[i]),      32'(w1[7-i]));
      chk("b2b_w2_bit", 32'(bl[11 + i]), 32'(w2[7-i]));
    end
    repeat (4) @(posedge clk);

    // mid-word reset
    @(posedge clk); #2;
    valid = 1'b1;
    data  = 8'hFF;
    @(posedge clk); #2;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("mid_pre_d",    32'(D),    32'd1);
    chk("mid_pre_hits", 32'(hits), 32'd1);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    _rst = 1'b0;
    #1 check_reset_vals("mid");
    @(posedge clk);
    @(posedge clk); #2;
    _rst = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("mid_no_done", 32'(seen_done), 32'd0);

    run_word(8'b1100_0000, dl, el, rl, d10, h10);
    chk("c0_expq", 32'(el), 32'b000_0000_0100);
    chk("c0_done", 32'(d10), 32'd1);
    chk("c0_hits", 32'(h10), 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
